// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_sequencer
// Purpose  : Bit-serial ADD/SUB/AND/XOR. It produces one result bit per clock,
//            LSB first, using a single 1-bit add cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int         c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_res_sr;
    logic [1:0]         r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic               w_arith;
    logic               w_h1_s, w_h1_c, w_h2_s, w_h2_c;
    logic               w_carry_nxt;
    logic               w_bit;
    logic [WIDTH-1:0]   w_res_nxt;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == c_last);
    assign w_arith  = ~r_op[1];

    // Two half-adders plus an OR for the carry make up the single full-add cell.
    assign w_h1_s      = r_sa[0] ^ r_sb[0];
    assign w_h1_c      = r_sa[0] & r_sb[0];
    assign w_h2_s      = w_h1_s ^ r_carry;
    assign w_h2_c      = w_h1_s & r_carry;
    assign w_carry_nxt = w_h1_c | w_h2_c;

    always_comb begin
        w_bit = w_h2_s;
        if (!w_arith) begin
            w_bit = r_op[0] ? w_h1_s : w_h1_c;
        end
    end

    assign w_res_nxt = (r_res_sr >> 1) | {w_bit, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa        <= '0;
            r_sb        <= '0;
            r_res_sr    <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            // SUB is performed as a + ~b + 1: invert B and preset the carry.
            r_sa    <= a;
            r_sb    <= (op == c_op_sub) ? ~b : b;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= (op == c_op_sub);
        end else if (r_state == S_RUN) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_res_sr <= w_res_nxt;
            r_cnt    <= r_cnt + c_cnt_w'(1);
            if (w_arith) begin
                r_carry <= w_carry_nxt;
            end
            // On the MSB step r_carry still holds the carry into the MSB.
            if (w_last) begin
                r_result    <= w_res_nxt;
                r_carry_out <= w_arith & w_carry_nxt;
                r_overflow  <= w_arith & (r_carry ^ w_carry_nxt);
                r_zero      <= (w_res_nxt == '0);
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_sequencer
// Purpose  : Directed scoreboard bench for serial_alu_sequencer (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_sequencer;

    localparam int WIDTH = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+2:0] exp_q[$];

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Expected packing: {result, carry_out, overflow, zero}
    function automatic logic [WIDTH+2:0] pack(input logic [WIDTH-1:0] r, input logic c,
                                              input logic v, input logic z);
        return {r, c, v, z};
    endfunction

    // Monitor: compares the flags against the scoreboard whenever done pulses.
    initial begin
        logic [WIDTH+2:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_flags", 32'({result, carry_out, overflow, zero}), 32'(e));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 3 * WIDTH);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic [WIDTH+2:0] e);
        int n;
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va; b = ~vb; op = ~o;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(n);
        check("latency", 32'(n), 32'(WIDTH));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        check("reset_state", 32'({busy, done, result, carry_out, overflow, zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_ADD, 8'hC8, 8'h64, pack(8'h2C, 1'b1, 1'b0, 1'b0));
        run_op(OP_SUB, 8'h05, 8'h07, pack(8'hFE, 1'b0, 1'b0, 1'b0));
        run_op(OP_SUB, 8'h30, 8'h30, pack(8'h00, 1'b1, 1'b0, 1'b1));
        run_op(OP_ADD, 8'h7F, 8'h01, pack(8'h80, 1'b0, 1'b1, 1'b0));
        run_op(OP_SUB, 8'h80, 8'h01, pack(8'h7F, 1'b1, 1'b1, 1'b0));
        run_op(OP_AND, 8'hF0, 8'h3C, pack(8'h30, 1'b0, 1'b0, 1'b0));

        // XOR, then start held high with new operands through RUN and DONE.
        @(negedge clk);
        op = OP_XOR; a = 8'hF0; b = 8'h3C; start = 1'b1;
        exp_q.push_back(pack(8'hCC, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        op = OP_ADD; a = 8'h01; b = 8'h01;
        check("result_held_in_run", 32'(result), 32'h30);
        wait_done(n);
        check("latency_xor", 32'(n), 32'(WIDTH));
        exp_q.push_back(pack(8'h02, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accept_busy", 32'({busy, done}), 32'b10);
        check("b2b_result_held", 32'(result), 32'hCC);
        n = 1;
        while (done !== 1'b1 && n < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_done_spacing", 32'(n), 32'(WIDTH + 1));
        @(posedge clk);
        #1;

        // Abort an ADD after three bit-steps with an asynchronous reset.
        @(negedge clk);
        op = OP_ADD; a = 8'h55; b = 8'h11; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({busy, done, result, carry_out, overflow, zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 32'({busy, done}), 32'd0);

        run_op(OP_ADD, 8'h10, 8'h20, pack(8'h30, 1'b0, 1'b0, 1'b0));

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
